// File: rtl/control_unit.sv
// Multicycle RV64 sequencer: fetches through a request/ready handshake, decodes the
// latched instruction and steps the dataflow through FETCH/DECODE/EXECUTE/MEM/COMMIT.
module control_unit #(
    parameter bit HaltOnIllegal = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] insn,
    input  logic [2:0]  flags_value,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        sel_pc_next,
    output logic        sel_pc_increment,
    output logic        sel_pc_jump,
    output logic        sel_alu_a,
    output logic        sel_alu_b,
    output logic        sel_mem_next,
    output logic        load_ins,
    output logic        load_imm,
    output logic        load_regfile,
    output logic        load_pc,
    output logic        load_rs1,
    output logic        load_rs2,
    output logic        load_alu,
    output logic        load_pc_alu,
    output logic        load_data_memory,
    output logic        load_flags,
    output logic [1:0]  sel_rd,
    output logic [2:0]  func3,
    output logic [2:0]  sel_mem_extension,
    output logic        sub_sra,
    output logic [4:0]  rd_addr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_COMMIT  = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_LUI     = 4'd0,
        C_AUIPC   = 4'd1,
        C_JAL     = 4'd2,
        C_JALR    = 4'd3,
        C_BRANCH  = 4'd4,
        C_LOAD    = 4'd5,
        C_STORE   = 4'd6,
        C_OPIMM   = 4'd7,
        C_OP      = 4'd8,
        C_ILLEGAL = 4'd9
    } class_t;

    // Branches with func3 010/011 have no defined condition and are treated as illegal.
    function automatic class_t decode_class(input logic [31:0] w);
        class_t c;
        case (w[6:0])
            7'b0110111: c = C_LUI;
            7'b0010111: c = C_AUIPC;
            7'b1101111: c = C_JAL;
            7'b1100111: c = C_JALR;
            7'b1100011: c = (w[14:13] == 2'b01) ? C_ILLEGAL : C_BRANCH;
            7'b0000011: c = C_LOAD;
            7'b0100011: c = C_STORE;
            7'b0010011: c = C_OPIMM;
            7'b0110011: c = C_OP;
            default:    c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    // flags are {lu, ls, eq}
    function automatic logic branch_taken(input logic [2:0] f3, input logic [2:0] fl);
        logic t;
        case (f3)
            3'b000:  t = fl[0];
            3'b001:  t = ~fl[0];
            3'b100:  t = fl[1];
            3'b101:  t = ~fl[1];
            3'b110:  t = fl[2];
            3'b111:  t = ~fl[2];
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    state_t state_r;
    state_t next_state_s;
    class_t class_s;
    logic   unused_insn_s;

    assign class_s       = decode_class(insn);
    assign rd_addr       = insn[11:7];
    assign rs1_addr      = insn[19:15];
    assign rs2_addr      = insn[24:20];
    assign unused_insn_s = ^{insn[31], insn[29:25]};

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and output decode; every output stays 0 while reset is high.
    always_comb begin
        next_state_s      = state_r;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        sel_pc_next       = 1'b0;
        sel_pc_increment  = 1'b0;
        sel_pc_jump       = 1'b0;
        sel_alu_a         = 1'b0;
        sel_alu_b         = 1'b0;
        sel_mem_next      = 1'b0;
        load_ins          = 1'b0;
        load_imm          = 1'b0;
        load_regfile      = 1'b0;
        load_pc           = 1'b0;
        load_rs1          = 1'b0;
        load_rs2          = 1'b0;
        load_alu          = 1'b0;
        load_pc_alu       = 1'b0;
        load_data_memory  = 1'b0;
        load_flags        = 1'b0;
        sel_rd            = 2'd0;
        func3             = 3'b000;
        sel_mem_extension = 3'b000;
        sub_sra           = 1'b0;
        illegal           = 1'b0;
        if (reset) begin
            next_state_s = S_FETCH;
        end else begin
            sel_mem_extension = insn[14:12];
            case (state_r)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    load_ins = mem_ready;
                    next_state_s = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    load_rs1 = 1'b1;
                    load_rs2 = 1'b1;
                    load_imm = 1'b1;
                    if (class_s == C_ILLEGAL) begin
                        next_state_s = HaltOnIllegal ? S_HALT : S_COMMIT;
                    end else begin
                        next_state_s = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    load_alu    = 1'b1;
                    load_flags  = 1'b1;
                    load_pc_alu = 1'b1;
                    case (class_s)
                        C_OP: begin
                            func3   = insn[14:12];
                            sub_sra = insn[30];
                        end
                        C_OPIMM: begin
                            sel_alu_b = 1'b1;
                            func3     = insn[14:12];
                            sub_sra   = (insn[14:12] == 3'b101) ? insn[30] : 1'b0;
                        end
                        C_LOAD, C_STORE, C_JALR: begin
                            sel_alu_b = 1'b1;
                        end
                        C_AUIPC, C_JAL: begin
                            sel_alu_a = 1'b1;
                            sel_alu_b = 1'b1;
                        end
                        C_BRANCH: begin
                            sub_sra = 1'b1;
                        end
                        default: begin
                            sub_sra = 1'b0;
                        end
                    endcase
                    if ((class_s == C_LOAD) || (class_s == C_STORE)) begin
                        next_state_s = S_MEM;
                    end else begin
                        next_state_s = S_COMMIT;
                    end
                end
                S_MEM: begin
                    mem_req          = 1'b1;
                    sel_mem_next     = 1'b1;
                    mem_we           = (class_s == C_STORE);
                    load_data_memory = (class_s == C_LOAD) && mem_ready;
                    next_state_s     = mem_ready ? S_COMMIT : S_MEM;
                end
                S_COMMIT: begin
                    load_pc      = 1'b1;
                    next_state_s = S_FETCH;
                    case (class_s)
                        C_LOAD: begin
                            load_regfile = 1'b1;
                            sel_rd       = 2'd0;
                        end
                        C_LUI: begin
                            load_regfile = 1'b1;
                            sel_rd       = 2'd1;
                        end
                        C_OP, C_OPIMM, C_AUIPC: begin
                            load_regfile = 1'b1;
                            sel_rd       = 2'd2;
                        end
                        C_JAL: begin
                            load_regfile     = 1'b1;
                            sel_rd           = 2'd3;
                            sel_pc_next      = 1'b1;
                            sel_pc_increment = 1'b1;
                        end
                        C_JALR: begin
                            load_regfile     = 1'b1;
                            sel_rd           = 2'd3;
                            sel_pc_next      = 1'b1;
                            sel_pc_increment = 1'b1;
                            sel_pc_jump      = 1'b1;
                        end
                        C_BRANCH: begin
                            if (branch_taken(insn[14:12], flags_value)) begin
                                sel_pc_next      = 1'b1;
                                sel_pc_increment = 1'b1;
                            end else begin
                                sel_pc_next      = 1'b0;
                            end
                        end
                        default: begin
                            load_regfile = 1'b0;
                        end
                    endcase
                end
                S_HALT: begin
                    illegal      = 1'b1;
                    next_state_s = S_HALT;
                end
                default: begin
                    next_state_s = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle vector table plus hand-written
// sequences for illegal handling (both HaltOnIllegal settings) and address fields.
module tb_control_unit;

    typedef struct packed {
        logic       mem_req, mem_we, sel_pc_next, sel_pc_increment, sel_pc_jump;
        logic       sel_alu_a, sel_alu_b, sel_mem_next, load_ins, load_imm;
        logic       load_regfile, load_pc, load_rs1, load_rs2, load_alu;
        logic       load_pc_alu, load_data_memory, load_flags;
        logic [1:0] sel_rd;
        logic [2:0] func3, sel_mem_extension;
        logic       sub_sra, illegal;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [31:0] insn;
        logic [2:0]  flags;
        logic        rdy;
        outs_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] insn;
    logic [2:0]  flags_value;
    logic        mem_ready;

    logic h_mem_req, h_mem_we, h_pcn, h_pci, h_pcj, h_a, h_b, h_mn, h_li, h_lim;
    logic h_lrf, h_lpc, h_lrs1, h_lrs2, h_lalu, h_lpca, h_ldm, h_lfl, h_sub, h_ill;
    logic [1:0] h_rd;
    logic [2:0] h_f3, h_ext;
    logic [4:0] h_rda, h_rs1a, h_rs2a;
    logic n_mem_req, n_mem_we, n_pcn, n_pci, n_pcj, n_a, n_b, n_mn, n_li, n_lim;
    logic n_lrf, n_lpc, n_lrs1, n_lrs2, n_lalu, n_lpca, n_ldm, n_lfl, n_sub, n_ill;
    logic [1:0] n_rd;
    logic [2:0] n_f3, n_ext;
    logic [4:0] n_rda, n_rs1a, n_rs2a;
    outs_t got_h, got_n;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    control_unit #(.HaltOnIllegal(1'b1)) dut_h (
        .clk(clk), .reset(reset), .insn(insn), .flags_value(flags_value), .mem_ready(mem_ready),
        .mem_req(h_mem_req), .mem_we(h_mem_we), .sel_pc_next(h_pcn), .sel_pc_increment(h_pci),
        .sel_pc_jump(h_pcj), .sel_alu_a(h_a), .sel_alu_b(h_b), .sel_mem_next(h_mn),
        .load_ins(h_li), .load_imm(h_lim), .load_regfile(h_lrf), .load_pc(h_lpc),
        .load_rs1(h_lrs1), .load_rs2(h_lrs2), .load_alu(h_lalu), .load_pc_alu(h_lpca),
        .load_data_memory(h_ldm), .load_flags(h_lfl), .sel_rd(h_rd), .func3(h_f3),
        .sel_mem_extension(h_ext), .sub_sra(h_sub), .rd_addr(h_rda), .rs1_addr(h_rs1a),
        .rs2_addr(h_rs2a), .illegal(h_ill)
    );

    control_unit #(.HaltOnIllegal(1'b0)) dut_n (
        .clk(clk), .reset(reset), .insn(insn), .flags_value(flags_value), .mem_ready(mem_ready),
        .mem_req(n_mem_req), .mem_we(n_mem_we), .sel_pc_next(n_pcn), .sel_pc_increment(n_pci),
        .sel_pc_jump(n_pcj), .sel_alu_a(n_a), .sel_alu_b(n_b), .sel_mem_next(n_mn),
        .load_ins(n_li), .load_imm(n_lim), .load_regfile(n_lrf), .load_pc(n_lpc),
        .load_rs1(n_lrs1), .load_rs2(n_lrs2), .load_alu(n_lalu), .load_pc_alu(n_lpca),
        .load_data_memory(n_ldm), .load_flags(n_lfl), .sel_rd(n_rd), .func3(n_f3),
        .sel_mem_extension(n_ext), .sub_sra(n_sub), .rd_addr(n_rda), .rs1_addr(n_rs1a),
        .rs2_addr(n_rs2a), .illegal(n_ill)
    );

    assign got_h = {h_mem_req, h_mem_we, h_pcn, h_pci, h_pcj, h_a, h_b, h_mn, h_li, h_lim,
                    h_lrf, h_lpc, h_lrs1, h_lrs2, h_lalu, h_lpca, h_ldm, h_lfl,
                    h_rd, h_f3, h_ext, h_sub, h_ill};
    assign got_n = {n_mem_req, n_mem_we, n_pcn, n_pci, n_pcj, n_a, n_b, n_mn, n_li, n_lim,
                    n_lrf, n_lpc, n_lrs1, n_lrs2, n_lalu, n_lpca, n_ldm, n_lfl,
                    n_rd, n_f3, n_ext, n_sub, n_ill};

    function automatic outs_t o_fetch(input logic rdy, input logic [2:0] ext);
        outs_t o = '0;
        o.mem_req = 1'b1; o.load_ins = rdy; o.sel_mem_extension = ext;
        return o;
    endfunction

    function automatic outs_t o_decode(input logic [2:0] ext);
        outs_t o = '0;
        o.load_rs1 = 1'b1; o.load_rs2 = 1'b1; o.load_imm = 1'b1; o.sel_mem_extension = ext;
        return o;
    endfunction

    function automatic outs_t o_exec(input logic [2:0] ext, input logic a, input logic b,
                                     input logic [2:0] f3, input logic sub);
        outs_t o = '0;
        o.load_alu = 1'b1; o.load_flags = 1'b1; o.load_pc_alu = 1'b1;
        o.sel_alu_a = a; o.sel_alu_b = b; o.func3 = f3; o.sub_sra = sub;
        o.sel_mem_extension = ext;
        return o;
    endfunction

    function automatic outs_t o_mem(input logic [2:0] ext, input logic we, input logic ldm);
        outs_t o = '0;
        o.mem_req = 1'b1; o.sel_mem_next = 1'b1; o.mem_we = we; o.load_data_memory = ldm;
        o.sel_mem_extension = ext;
        return o;
    endfunction

    function automatic outs_t o_commit(input logic [2:0] ext, input logic rf, input logic [1:0] rd,
                                       input logic pcn, input logic inc, input logic jmp);
        outs_t o = '0;
        o.load_pc = 1'b1; o.load_regfile = rf; o.sel_rd = rd;
        o.sel_pc_next = pcn; o.sel_pc_increment = inc; o.sel_pc_jump = jmp;
        o.sel_mem_extension = ext;
        return o;
    endfunction

    function automatic outs_t o_halt(input logic [2:0] ext);
        outs_t o = '0;
        o.illegal = 1'b1; o.sel_mem_extension = ext;
        return o;
    endfunction

    task automatic add(input logic rst, input logic [31:0] w, input logic [2:0] fl,
                       input logic rdy, input outs_t e);
        vec_t v;
        v.rst = rst; v.insn = w; v.flags = fl; v.rdy = rdy; v.exp = e;
        vecs.push_back(v);
    endtask

    // Zero-wait four-cycle instruction: FETCH, DECODE, EXECUTE, COMMIT.
    task automatic add4(input logic [31:0] w, input logic [2:0] ext, input logic [2:0] fl,
                        input logic a, input logic b, input logic [2:0] f3, input logic sub,
                        input logic rf, input logic [1:0] rd,
                        input logic pcn, input logic inc, input logic jmp);
        add(1'b0, w, fl, 1'b1, o_fetch(1'b1, ext));
        add(1'b0, w, fl, 1'b1, o_decode(ext));
        add(1'b0, w, fl, 1'b1, o_exec(ext, a, b, f3, sub));
        add(1'b0, w, fl, 1'b1, o_commit(ext, rf, rd, pcn, inc, jmp));
    endtask

    task automatic drive(input logic rst, input logic [31:0] w, input logic [2:0] fl,
                         input logic rdy);
        reset = rst; insn = w; flags_value = fl; mem_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h required %h", name, idx, got, exp);
        end
    endtask

    task automatic chk_addr(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    // Illegal instruction from FETCH: halt variant parks in HALT, NOP variant commits and loops.
    task automatic illegal_seq(input logic [31:0] w, input logic [2:0] ext, input int tag);
        outs_t zero = '0;
        drive(1'b0, w, 3'b000, 1'b1);
        @(negedge clk); chk("ill_fetch_h", tag, got_h, o_fetch(1'b1, ext));
        chk("ill_fetch_n", tag, got_n, o_fetch(1'b1, ext)); tick();
        @(negedge clk); chk("ill_decode_h", tag, got_h, o_decode(ext));
        chk("ill_decode_n", tag, got_n, o_decode(ext)); tick();
        @(negedge clk); chk("ill_halt_h", tag, got_h, o_halt(ext));
        chk("ill_nop_commit_n", tag, got_n, o_commit(ext, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)); tick();
        @(negedge clk); chk("ill_halt_h", tag + 1, got_h, o_halt(ext));
        chk("ill_refetch_n", tag, got_n, o_fetch(1'b1, ext)); tick();
        @(negedge clk); chk("ill_halt_h", tag + 2, got_h, o_halt(ext)); tick();
        drive(1'b1, w, 3'b000, 1'b1);
        @(negedge clk); chk("ill_reset_h", tag, got_h, zero);
        chk("ill_reset_n", tag, got_n, zero); tick();
        drive(1'b0, w, 3'b000, 1'b0);
        @(negedge clk); chk("ill_postreset_h", tag, got_h, o_fetch(1'b0, ext));
        chk("ill_postreset_n", tag, got_n, o_fetch(1'b0, ext)); tick();
    endtask

    initial begin
        outs_t zero = '0;

        // Address fields are combinational and stay live during reset.
        drive(1'b1, 32'h000280E7, 3'b000, 1'b0);
        @(negedge clk);
        chk_addr("jalr_rd_addr", h_rda, 5'd1);
        chk_addr("jalr_rs1_addr", h_rs1a, 5'd5);
        chk_addr("jalr_rs2_addr_n", n_rs2a, 5'd0);
        chk("reset_outs", 0, got_h, zero);
        tick();
        drive(1'b1, 32'h00500093, 3'b000, 1'b0);
        @(negedge clk);
        chk_addr("addi_rs2_addr", h_rs2a, 5'd5);
        chk_addr("addi_rs1_addr_n", n_rs1a, 5'd0);
        chk_addr("addi_rd_addr_n", n_rda, 5'd1);
        tick();

        // ADDI x1,x0,5
        add4(32'h00500093, 3'd0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        // LD x2,8(x3): one fetch wait, three memory waits
        add(1'b0, 32'h0081B103, 3'b000, 1'b0, o_fetch(1'b0, 3'd3));
        add(1'b0, 32'h0081B103, 3'b000, 1'b1, o_fetch(1'b1, 3'd3));
        add(1'b0, 32'h0081B103, 3'b000, 1'b1, o_decode(3'd3));
        add(1'b0, 32'h0081B103, 3'b000, 1'b1, o_exec(3'd3, 1'b0, 1'b1, 3'b000, 1'b0));
        for (int i = 0; i < 3; i++) add(1'b0, 32'h0081B103, 3'b000, 1'b0, o_mem(3'd3, 1'b0, 1'b0));
        add(1'b0, 32'h0081B103, 3'b000, 1'b1, o_mem(3'd3, 1'b0, 1'b1));
        add(1'b0, 32'h0081B103, 3'b000, 1'b1, o_commit(3'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
        // BNE: eq set -> not taken; eq clear -> taken
        add4(32'h00209463, 3'd1, 3'b001, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        add4(32'h00209463, 3'd1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        // JALR x1,0(x5)
        add4(32'h000280E7, 3'd0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
        // SD x2,16(x3), zero-wait
        add(1'b0, 32'h0021B823, 3'b000, 1'b1, o_fetch(1'b1, 3'd3));
        add(1'b0, 32'h0021B823, 3'b000, 1'b1, o_decode(3'd3));
        add(1'b0, 32'h0021B823, 3'b000, 1'b1, o_exec(3'd3, 1'b0, 1'b1, 3'b000, 1'b0));
        add(1'b0, 32'h0021B823, 3'b000, 1'b1, o_mem(3'd3, 1'b1, 1'b0));
        add(1'b0, 32'h0021B823, 3'b000, 1'b1, o_commit(3'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0));
        // SUB x3,x1,x2
        add4(32'h402081B3, 3'd0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        // SRAI x1,x1,3
        add4(32'h4030D093, 3'd5, 3'b000, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        // ADDI x1,x0,0x400: bit 30 set but no sub for func3 000
        add4(32'h40000093, 3'd0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        // LUI x5,0x12345
        add4(32'h123452B7, 3'd5, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        // AUIPC x1,1
        add4(32'h00001097, 3'd1, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        // JAL x1,8
        add4(32'h008000EF, 3'd0, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
        // BLTU with lu set -> taken
        add4(32'h0020E463, 3'd6, 3'b100, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        // BGE with ls set -> not taken
        add4(32'h0020D463, 3'd5, 3'b010, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        // Reset for two cycles while LD waits in MEM
        add(1'b0, 32'h0081B103, 3'b000, 1'b1, o_fetch(1'b1, 3'd3));
        add(1'b0, 32'h0081B103, 3'b000, 1'b1, o_decode(3'd3));
        add(1'b0, 32'h0081B103, 3'b000, 1'b1, o_exec(3'd3, 1'b0, 1'b1, 3'b000, 1'b0));
        add(1'b0, 32'h0081B103, 3'b000, 1'b0, o_mem(3'd3, 1'b0, 1'b0));
        add(1'b1, 32'h0081B103, 3'b000, 1'b0, zero);
        add(1'b1, 32'h0081B103, 3'b000, 1'b0, zero);
        add(1'b0, 32'h0081B103, 3'b000, 1'b0, o_fetch(1'b0, 3'd3));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].insn, vecs[i].flags, vecs[i].rdy);
            @(negedge clk);
            chk("vec_h", i, got_h, vecs[i].exp);
            chk("vec_n", i, got_n, vecs[i].exp);
            tick();
        end

        illegal_seq(32'h0000007F, 3'd0, 100);
        illegal_seq(32'h0020A463, 3'd2, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
